// File: rtl/mux_scan_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan display.
// State encodings, blanking patterns and default timing constants.
package mux_scan_display_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [2:0] AN_OFF  = 3'b111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam int DEF_PRESC     = 50000;
    localparam int DEF_BLANK_CYC = 2;

    // Active-low one-cold anode pattern for a digit index
    function automatic logic [2:0] an_sel(input logic [1:0] idx);
        an_sel = ~(3'b001 << idx);
    endfunction

endpackage

// File: rtl/mux_scan_display_hex7seg.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
// Purely combinational.
module mux_scan_display_hex7seg (
    input  logic [3:0] d,
    output logic [6:0] seg
);

    // Standard hex glyphs 0-F
    always_comb begin
        seg = 7'b1111111;
        unique case (d)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/mux_scan_display.sv
// Scan controller: drives the operand select, latches the returned value
// and time-multiplexes it onto a 3-digit common-anode display.
module mux_scan_display
    import mux_scan_display_pkg::*;
#(
    parameter int N         = 4,
    parameter int PRESC     = DEF_PRESC,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         step,
    input  logic [N-1:0] y,
    output logic [1:0]   s,
    output logic [2:0]   an,
    output logic [6:0]   seg,
    output logic         dp
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(PRESC - 1);
    localparam logic [3:0]    B_MAX = 4'(BLANK_CYC - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [2:0]    sync_q, sync_d;
    logic          pulse_q, pulse_d;
    logic          tick;
    logic          advance;
    logic [3:0]    y4;
    logic [6:0]    seg_w;

    assign y4 = 4'(y);

    mux_scan_display_hex7seg u_hex (
        .d   (y4),
        .seg (seg_w)
    );

    // Button synchroniser plus one-cycle rising-edge pulse
    always_comb begin
        sync_d  = {sync_q[1:0], step};
        pulse_d = sync_q[1] & ~sync_q[2];
    end

    // Prescaler only runs while auto-scanning a lit digit
    always_comb begin
        tick    = en && (state_q == ST_SHOW) && (pcnt_q == P_MAX);
        advance = (state_q == ST_SHOW) && (tick || pulse_q);
        if (!en || (state_q != ST_SHOW) || advance)
            pcnt_d = '0;
        else
            pcnt_d = pcnt_q + 1'b1;
    end

    // Blank/show sequencing, latches the selected digit at end of blank
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        unique case (state_q)
            ST_BLANK: begin
                an_d = AN_OFF;
                if (bcnt_q == B_MAX) begin
                    seg_d   = seg_w;
                    dp_d    = ~(idx_q == 2'd2);
                    an_d    = an_sel(idx_q);
                    bcnt_d  = '0;
                    state_d = ST_SHOW;
                end else begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            ST_SHOW: begin
                if (advance) begin
                    idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    an_d    = AN_OFF;
                    state_d = ST_BLANK;
                end
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_BLANK;
            pcnt_q  <= '0;
            bcnt_q  <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign s   = idx_q;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: doc/mux_scan_display.md
Name: mux_scan_display

Overview:
- Scan controller that sits around the 3-to-1 operand selector stage.
- Upstream role: drives the selector's 2-bit select `s`, cycling 0,1,2.
- Downstream role: consumes the selected 4-bit result `y` and shows it on a 3-digit common-anode 7-segment display, so the a/b/c operands appear side by side.
- Supports free-running scan and a frozen/manual-step mode driven by a push button.

Parameters:
- N, 4, width of `y`; hex decode uses y[3:0]; legal values 1..4, with upper bits zero-extended when N<4.
- PRESC, 50000, clk cycles per digit slot in auto mode; legal values ≥ 4.
- BLANK_CYC, 2, clk cycles all anodes are off between digits (anti-ghosting); legal values 1..15.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- en  in  1  1 = auto scan, 0 = hold current digit (manual step only).
- step  in  1  raw push button, asynchronous, active-high.
- y  in  N  selected operand returned from the selector stage (combinational function of `s`).
- s  out  2  select to the selector stage; registered; value 3 is never driven.
- an  out  3  digit anodes, active-low; an[0] shows `s`=0.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low; registered.
- dp  out  1  decimal point, active-low; lit only on digit 2.

Behaviour:
- Async reset (clr_n=0), effective immediately, including mid-blank or mid-show:
  - s=0, idx=0, an=3'b111, seg=7'b1111111, dp=1
  - prescaler=0, blank counter=0, state=BLANK
  - step synchroniser flops=0
- step conditioning:
  - 2-FF synchroniser, then rising-edge detect.
  - step_pulse is one clk wide, 3 cycles after the synchronised edge reaches the first flop.
  - No debounce in this block; bounces produce multiple steps.
- Prescaler:
  - Counts 0..PRESC-1 while en=1 and state=SHOW.
  - tick=1 in the cycle count==PRESC-1, then wraps to 0.
  - Held at 0 while en=0 or state=BLANK.
- advance = (tick | step_pulse) while in SHOW. Simultaneous tick and step_pulse cause exactly one advance. step_pulse during BLANK is ignored.
- FSM, two states:
  - BLANK:
    - an=3'b111, blank counter increments each cycle.
    - At count==BLANK_CYC-1: latch seg<=hex7(y), dp<=~(idx==2), an<=~(1<<idx), clear counter, go to SHOW.
  - SHOW:
    - an, seg, dp stable.
    - On advance: idx<=(idx==2)?0:idx+1, s<=same value, an<=3'b111, go to BLANK.
- Timing:
  - `s` changes on entry to BLANK, so `y` has ≥1 full cycle to settle before it is latched (BLANK_CYC≥1).
  - Reset-release to first lit digit is BLANK_CYC cycles.
  - Auto-mode digit period is PRESC+BLANK_CYC cycles.
- Wrap-around: idx and s go 2→0; never 3.
- en falling during SHOW: current digit stays lit indefinitely; the prescaler clears.
- en rising: the prescaler restarts from 0.
- y changing during SHOW is not reflected until the next visit to that digit (seg is registered).
- Decode: standard hex 0–F. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.

Decomposition:
- Shared package/header:
  - state encodings ST_BLANK=1'b0, ST_SHOW=1'b1
  - AN_OFF=3'b111, SEG_OFF=7'b1111111
  - default PRESC/BLANK_CYC constants reused by other display labs
- One sub-module: hex7seg (pure combinational 4-bit → 7-bit active-low decoder), instantiated once. Prescaler, synchroniser and FSM stay in the top.

Test Plan (PRESC=8, BLANK_CYC=2, bench models selector: y=a/b/c by s, a=4'h1, b=4'hA, c=4'hF):
- Reset then release, en=1 → cycles 0–1 an=111; cycle 2 an=110, seg=7'b1111001, dp=1, s=0; after 8 more cycles s=1, an=111, then an=101, seg=7'b0001000.
- Auto scan for 3 full digit periods (30 cycles) → s sequence 0,1,2,0; an=011 with dp=0 only while s=2; s never 3.
- en=0 while showing digit 1, hold 100 cycles → an=101 and s=1 constant; one step pulse (≥4 cycles high) → exactly one advance to s=2 after sync + 2 blank cycles.
- en=1 with a step edge timed to coincide with tick → single advance (s 0→1, not 0→2).
- Assert clr_n low mid-BLANK while s=2 → same cycle an=111, seg=1111111, s=0; after release, digit 0 shows after 2 cycles.
- Change a to 4'h8 while digit 0 is showing → seg unchanged until next visit, then seg=7'b0000000.
